// File: rtl/if_prefetch_pkg.sv
// Shared constants for the prefetching fetch stage: control-level encodings,
// default bus widths, the PC step and the queue count-width helper.
package if_prefetch_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  localparam int unsigned PC_INC = 4;

  // Counter width that can represent every value in 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_inst_queue.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs for ID.
// Owns pointer wrap and occupancy; clear (flush) outranks push and pop.
module inst_queue
  import if_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push;
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE && !clear && do_push)
      mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  assert property (@(posedge clk) disable iff (rst || clear) !(do_push && full && !do_pop));

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage with a one-deep in-flight ROM request and a DEPTH-entry
// instruction queue feeding ID; branch redirects flush everything queued.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int              ADDR_W   = INST_ADDR_BUS_W,
  parameter int              INST_W   = INST_BUS_W,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int QW    = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic [QW-1:0]     head_data;
  logic              in_reset;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    credit_need;

  assign in_reset = (rst == RST_ENABLE);

  // Occupancy after this cycle if we issue: queued + in flight - leaving now.
  assign pop         = id_valid_o & ~stall_i;
  assign credit_need = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue       = ~in_reset & ~branch_flag_i & (credit_need < (CNT_W+1)'(DEPTH));
  assign push        = inflight_q & ~branch_flag_i;

  assign rom_ce_o   = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = issue ? fetch_pc : '0;

  assign id_valid_o = ~in_reset & ~empty;
  assign id_pc_o    = id_valid_o ? head_data[QW-1:INST_W] : '0;
  assign id_inst_o  = id_valid_o ? head_data[INST_W-1:0]  : '0;

  // A redirect drops the response arriving now and restarts at the target.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      fetch_pc      <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (branch_flag_i) begin
      fetch_pc   <= branch_target_i;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fetch_pc      <= fetch_pc + ADDR_W'(PC_INC);
        inflight_pc_q <= fetch_pc;
      end
    end
  end

  inst_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_flag_i),
    .push      (push),
    .pop       (pop),
    .push_data ({inflight_pc_q, rom_data_i}),
    .head_data (head_data),
    .count     (count),
    .empty     (empty)
  );

  assert property (@(posedge clk) disable iff (rst)
    (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q) <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: an expected-PC queue is loaded on reset
// and redirect, and drained whenever ID consumes a head entry.
module tb_if_prefetch;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stall_a, br_a;
  logic [31:0] tgt_a, rom_addr_a, rom_data_a, id_pc_a, id_inst_a;
  logic        rom_ce_a, id_valid_a;

  logic        rst_b;
  logic        stall_b = 1'b0;
  logic        br_b    = 1'b0;
  logic [31:0] tgt_b   = 32'h0;
  logic [31:0] rom_addr_b, rom_data_b, id_pc_b, id_inst_b;
  logic        rom_ce_b, id_valid_b;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          pop_cnt      = 0;
  logic [31:0] exp_q [$];

  if_prefetch dut_a (
    .clk             (clk),
    .rst             (rst_a),
    .rom_ce_o        (rom_ce_a),
    .rom_addr_o      (rom_addr_a),
    .rom_data_i      (rom_data_a),
    .stall_i         (stall_a),
    .branch_flag_i   (br_a),
    .branch_target_i (tgt_a),
    .id_valid_o      (id_valid_a),
    .id_pc_o         (id_pc_a),
    .id_inst_o       (id_inst_a)
  );

  if_prefetch #(.RESET_PC(WRAP_PC)) dut_b (
    .clk             (clk),
    .rst             (rst_b),
    .rom_ce_o        (rom_ce_b),
    .rom_addr_o      (rom_addr_b),
    .rom_data_i      (rom_data_b),
    .stall_i         (stall_b),
    .branch_flag_i   (br_b),
    .branch_target_i (tgt_b),
    .id_valid_o      (id_valid_b),
    .id_pc_o         (id_pc_b),
    .id_inst_o       (id_inst_b)
  );

  // One-cycle ROM; idle cycles return a poison word so stale data shows up.
  always @(posedge clk) begin
    rom_data_a <= rom_ce_a ? (32'hA500_0000 | rom_addr_a) : 32'hDEAD_BEEF;
    rom_data_b <= rom_ce_b ? (32'hA500_0000 | rom_addr_b) : 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst_a   = r;
    stall_a = s;
    br_a    = b;
    tgt_a   = t;
    if (r) begin
      exp_q.delete();
      pop_cnt = 0;
      for (int i = 0; i < 24; i++) exp_q.push_back(32'(4 * i));
    end else if (b) begin
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(t + 32'(4 * i));
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rst_ce"},    64'(rom_ce_a),   64'd0);
    checkOutput({tag, "_rst_addr"},  64'(rom_addr_a), 64'd0);
    checkOutput({tag, "_rst_valid"}, 64'(id_valid_a), 64'd0);
    checkOutput({tag, "_rst_pc"},    64'(id_pc_a),    64'd0);
    checkOutput({tag, "_rst_inst"},  64'(id_inst_a),  64'd0);
  endtask

  task automatic endPhase(input string tag, input int exp_pops);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    checkOutput(tag, 64'(pop_cnt), 64'(exp_pops));
  endtask

  // Scoreboard side: every consumed head must be the next expected PC.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (!rom_ce_a)
        checkOutput("addr_idle", 64'(rom_addr_a), 64'd0);
      if (id_valid_a)
        checkOutput("inst_match", 64'(id_inst_a), 64'(32'hA500_0000 | id_pc_a));
      else
        checkOutput("inst_nop", 64'(id_inst_a), 64'd0);
      if (id_valid_a && !stall_a && !br_a) begin
        checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          checkOutput("pc_seq", 64'(id_pc_a), 64'(exp_q.pop_front()));
        pop_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_a = 1'b1; stall_a = 1'b0; br_a = 1'b0; tgt_a = 32'h0; rst_b = 1'b1;

    // Streaming from reset
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkResetOutputs("p1a");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkResetOutputs("p1b");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("p1_ce",    64'(rom_ce_a),   64'd1);
      checkOutput("p1_addr",  64'(rom_addr_a), 64'(4 * k));
      checkOutput("p1_valid", 64'(id_valid_a), 64'(k >= 2));
    end
    endPhase("p1_pops", 6);

    // Stall from first valid for 10 cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, (k >= 2 && k < 12), 1'b0, 32'h0);
      if (k >= 2 && k < 12) begin
        checkOutput("p2_hold_valid", 64'(id_valid_a), 64'd1);
        checkOutput("p2_hold_pc",    64'(id_pc_a),    64'd0);
        checkOutput("p2_ce",         64'(rom_ce_a),   64'(k < 4));
      end
      if (k >= 12)
        checkOutput("p2_no_bubble", 64'(id_valid_a), 64'd1);
    end
    endPhase("p2_pops", 8);

    // Redirect to 0x100 while 0x8 is at the head and 0xC is in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 4), (k == 4) ? 32'h100 : 32'h0);
      case (k)
        4: begin
          checkOutput("p3_head_T", 64'(id_pc_a),  64'h8);
          checkOutput("p3_ce_T",   64'(rom_ce_a), 64'd0);
        end
        5: begin
          checkOutput("p3_valid_T1", 64'(id_valid_a), 64'd0);
          checkOutput("p3_ce_T1",    64'(rom_ce_a),   64'd1);
          checkOutput("p3_addr_T1",  64'(rom_addr_a), 64'h100);
        end
        6: begin
          checkOutput("p3_valid_T2", 64'(id_valid_a), 64'd0);
          checkOutput("p3_addr_T2",  64'(rom_addr_a), 64'h104);
        end
        7: begin
          checkOutput("p3_valid_T3", 64'(id_valid_a), 64'd1);
          checkOutput("p3_pc_T3",    64'(id_pc_a),    64'h100);
        end
        8: checkOutput("p3_pc_T4", 64'(id_pc_a), 64'h104);
        default: ;
      endcase
    end
    endPhase("p3_pops", 6);

    // Full queue under stall, redirect to 0x40 in the same cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, (k >= 2 && k <= 6), (k == 6), (k == 6) ? 32'h40 : 32'h0);
      case (k)
        5: checkOutput("p4_full_ce", 64'(rom_ce_a), 64'd0);
        6: begin
          checkOutput("p4_ce_T",   64'(rom_ce_a), 64'd0);
          checkOutput("p4_head_T", 64'(id_pc_a),  64'h0);
        end
        7: begin
          checkOutput("p4_valid_T1", 64'(id_valid_a), 64'd0);
          checkOutput("p4_addr_T1",  64'(rom_addr_a), 64'h40);
        end
        9: begin
          checkOutput("p4_valid_T3", 64'(id_valid_a), 64'd1);
          checkOutput("p4_pc_T3",    64'(id_pc_a),    64'h40);
        end
        default: ;
      endcase
    end
    endPhase("p4_pops", 3);

    // Reset with entries queued and a request in flight
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, (k >= 2), 1'b0, 32'h0);
    checkOutput("p5_pre_ce", 64'(rom_ce_a), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkResetOutputs("p5");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (k == 0) checkOutput("p5_restart_addr", 64'(rom_addr_a), 64'h0);
      if (k < 2)  checkOutput("p5_no_stale",     64'(id_valid_a), 64'd0);
      if (k == 2) checkOutput("p5_first_pc",     64'(id_pc_a),    64'h0);
    end
    endPhase("p5_pops", 4);

    // PC wrap from RESET_PC = 0xFFFFFFF8
    for (int k = 0; k < 6; k++) begin
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(negedge clk);
      e_addr = WRAP_PC + 32'(4 * k);
      e_pc   = WRAP_PC + 32'(4 * (k - 2));
      checkOutput("p6_addr", 64'(rom_addr_b), 64'(e_addr));
      if (k >= 2) begin
        checkOutput("p6_valid", 64'(id_valid_b), 64'd1);
        checkOutput("p6_pc",    64'(id_pc_b),    64'(e_pc));
        checkOutput("p6_inst",  64'(id_inst_b),  64'(32'hA500_0000 | e_pc));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
